// File: rtl/io_bus_master.sv
// Initiator for the port_io peripheral bus: turns accepted commands into
// address/data/strobe cycles and returns a one-cycle completion response.
module io_bus_master #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [7:0]  IDLE_ADDR   = 8'h00
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_write,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [7:0] abus,
  inout  wire  [7:0] dbus,
  output logic       wr_en,
  output logic       rd_en,
  output logic [2:0] state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is high only while the FSM sits in IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WSTROBE = 3'd2,
    WHOLD   = 3'd3,
    RSTROBE = 3'd4,
    RDONE   = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       write_q;
  logic [7:0] wdata_q;
  logic       drive_q;

  // Bus output enable is a flop so dbus only ever changes on a clock edge.
  assign dbus      = drive_q ? wdata_q : 8'hzz;
  assign state_dbg = state;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
      abus      <= IDLE_ADDR;
      drive_q   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= 8'h00;
      wait_cnt  <= 4'd0;
      write_q   <= 1'b0;
      wdata_q   <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            abus      <= cmd_addr;
            write_q   <= cmd_write;
            wdata_q   <= cmd_wdata;
            drive_q   <= cmd_write;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        SETUP: begin
          if (write_q) begin
            state <= WSTROBE;
            wr_en <= 1'b1;
          end else begin
            state    <= RSTROBE;
            rd_en    <= 1'b1;
            wait_cnt <= WAIT_INIT;
          end
        end
        WSTROBE: begin
          state     <= WHOLD;
          wr_en     <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_write <= 1'b1;
        end
        RSTROBE: begin
          // Sample the responder on the edge that ends the final strobe cycle.
          if (wait_cnt == 4'd0) begin
            state     <= RDONE;
            rd_en     <= 1'b0;
            rsp_rdata <= dbus;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WHOLD, RDONE: begin
          state     <= IDLE;
          abus      <= IDLE_ADDR;
          drive_q   <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: directed scenarios plus a long random run, all
// checked cycle by cycle against a transaction-timeline reference model.
module tb_io_bus_master;

  localparam int         W  = 2;
  localparam logic [7:0] IA = 8'h00;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_write, busy, wr_en, rd_en;
  logic [7:0] rsp_rdata, abus;
  logic [2:0] state_dbg;
  wire  [7:0] dbus;

  // Responder: drives a value whenever the master is not expected to drive.
  logic       resp_en = 1'b1;
  logic [7:0] resp_val = 8'h00;
  assign dbus = resp_en ? resp_val : 8'hzz;

  io_bus_master #(.WAIT_CYCLES(W), .IDLE_ADDR(IA)) dut (
    .clk_in(clk_in), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .busy(busy), .abus(abus), .dbus(dbus), .wr_en(wr_en), .rd_en(rd_en),
    .state_dbg(state_dbg)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: t_m counts cycles since the accept edge of the
  // transaction in flight; every output is a function of that offset.
  bit         act_m = 1'b0;
  bit         rdy_m = 1'b0;
  bit         w_m = 1'b0;
  int         t_m = 0;
  logic [7:0] a_m = 8'h00;
  logic [7:0] d_m = 8'h00;
  logic [7:0] rdata_m = 8'h00;
  bit         accepted = 1'b0;
  bit         fixed_resp = 1'b0;
  logic [7:0] fixed_val = 8'h00;
  int         n_acc = 0;
  int         n_abort = 0;
  int         n_rsp = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int last_t();
    return w_m ? 3 : W + 3;
  endfunction

  task automatic model_edge();
    accepted = 1'b0;
    if (rst) return;
    if (!act_m) begin
      if (rdy_m && cmd_valid) begin
        act_m = 1'b1; t_m = 1; w_m = cmd_write; a_m = cmd_addr; d_m = cmd_wdata;
        rdy_m = 1'b0; accepted = 1'b1; n_acc++;
      end else begin
        rdy_m = 1'b1;
      end
    end else begin
      if (!w_m && t_m == W + 2) begin
        rdata_m = resp_val;
        exp_q.push_back(resp_val);
      end
      t_m++;
      if (t_m > last_t()) begin
        act_m = 1'b0;
        rdy_m = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    bit drv, rv;
    drv = act_m && w_m;
    rv  = act_m && (t_m == last_t());
    check("cmd_ready", 32'(cmd_ready), 32'(rdy_m));
    check("busy", 32'(busy), 32'(!rdy_m));
    check("abus", 32'(abus), 32'(act_m ? a_m : IA));
    check("dbus", 32'(dbus), 32'(drv ? d_m : resp_val));
    check("wr_en", 32'(wr_en), 32'(drv && t_m == 2));
    check("rd_en", 32'(rd_en), 32'(act_m && !w_m && t_m >= 2 && t_m <= W + 2));
    check("rsp_valid", 32'(rsp_valid), 32'(rv));
    if (rv) check("rsp_write", 32'(rsp_write), 32'(w_m));
    if (rst) check("rst_rsp_write", 32'(rsp_write), 32'(0));
    check("rsp_rdata", 32'(rsp_rdata), 32'(rdata_m));
    check("strobe_excl", 32'(wr_en & rd_en), 32'(0));
    if (rsp_valid) n_rsp++;
    if (rsp_valid && !rsp_write) begin
      if (exp_q.size() == 0) check("rd_queue_empty", 32'(1), 32'(0));
      else check("rd_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    resp_en  = !(act_m && w_m);
    resp_val = fixed_resp ? fixed_val : 8'($urandom);
    #1;
    check_all();
  endtask

  task automatic run_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) check("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input bit noise);
    for (int i = 0; i < 60 && (act_m || !rdy_m); i++) begin
      if (noise && act_m) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    cmd_valid = 1'b0;
    if (act_m || !rdy_m) check("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    if (act_m && t_m < last_t()) n_abort++;
    act_m = 1'b0; rdy_m = 1'b0; rdata_m = 8'h00;
    exp_q.delete();
    resp_en = 1'b1;
    #1;
    check_all();
    check("rst_state", 32'(state_dbg), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int target;
    int cycles;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_cmd(1'b1, 8'h00, 8'hA5);
    cmd_valid = 1'b0;
    wait_idle(1'b0);

    fixed_resp = 1'b1;
    fixed_val  = 8'h3C;
    run_cmd(1'b0, 8'h00, 8'h00);
    cmd_valid = 1'b0;
    wait_idle(1'b0);
    fixed_resp = 1'b0;
    check("read_3c", 32'(rsp_rdata), 32'(8'h3C));

    run_cmd(1'b1, 8'h12, 8'h34);
    run_cmd(1'b0, 8'h56, 8'h00);
    cmd_valid = 1'b0;
    wait_idle(1'b0);

    run_cmd(1'b0, 8'h9A, 8'h00);
    wait_idle(1'b1);
    run_cmd(1'b1, 8'hBC, 8'hDE);
    wait_idle(1'b1);

    run_cmd(1'b1, 8'h7E, 8'hC3);
    cmd_valid = 1'b0;
    tick();
    do_reset();

    target = n_acc + 1000;
    cycles = 0;
    while (n_acc < target && cycles < 20000) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 8'($urandom);
      cmd_wdata = 8'($urandom);
      tick();
      cycles++;
    end
    cmd_valid = 1'b0;
    wait_idle(1'b0);
    if (n_acc < target) check("random_accept_budget", 32'(n_acc), 32'(target));
    check("rsp_count", 32'(n_rsp), 32'(n_acc - n_abort));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, extra rd_en cycles per read (legal 0..15).
REQ-002 Parameter IDLE_ADDR, default 8'h00, value driven on abus when no transaction is active.
REQ-003 clk_in  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cmd_valid  input  1  request present.
REQ-006 cmd_ready  output  1  master can accept a request.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  8  target peripheral address.
REQ-009 cmd_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_write  output  1  type of the completed transaction.
REQ-012 rsp_rdata  output  8  captured read data; holds its value until the next read completes.
REQ-013 busy  output  1  transaction in progress (inverse of cmd_ready).
REQ-014 abus  output  8  peripheral address bus.
REQ-015 dbus  inout  8  shared data bus; master drives it on writes only, otherwise high-Z.
REQ-016 wr_en  output  1  peripheral write strobe.
REQ-017 rd_en  output  1  peripheral read enable.

Function
REQ-018 Initiator side of the port_io bus: the block SHALL turn command requests into abus/dbus/wr_en/rd_en cycles.
REQ-019 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_addr, cmd_write and cmd_wdata SHALL be registered at that edge.
REQ-020 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE SHALL be ignored with no side effect.
REQ-021 FSM states SHALL be IDLE, SETUP, WSTROBE, WHOLD, RSTROBE, RDONE.
REQ-022 Transitions SHALL be: IDLE->SETUP on accept; SETUP->WSTROBE (write) or RSTROBE (read); WSTROBE->WHOLD; WHOLD->IDLE; RSTROBE->RDONE after WAIT_CYCLES+1 cycles; RDONE->IDLE.
REQ-023 abus SHALL equal the registered address from SETUP through WHOLD/RDONE, and SHALL equal IDLE_ADDR in IDLE.
REQ-024 dbus SHALL be driven with the registered wdata in SETUP, WSTROBE and WHOLD of a write, and SHALL be high-Z in every other state.
REQ-025 wr_en SHALL be 1 only in WSTROBE, for exactly one cycle.
REQ-026 rd_en SHALL be 1 only in RSTROBE, for exactly WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter.
REQ-027 On the rising edge that ends the last RSTROBE cycle, the block SHALL capture dbus into rsp_rdata.
REQ-028 rsp_valid SHALL be 1 for exactly one cycle, in WHOLD for writes and in RDONE for reads; rsp_write SHALL be valid in that same cycle.
REQ-029 Latency from the accept edge to the rsp_valid cycle SHALL be 3 cycles for writes and WAIT_CYCLES+3 cycles for reads; cmd_ready SHALL return on the following cycle.
REQ-030 wr_en and rd_en SHALL never be 1 in the same cycle.
REQ-031 dbus SHALL never be driven while rd_en=1.
REQ-032 Back-to-back commands SHALL have at least one IDLE cycle between a transaction's last strobe and the next SETUP.
REQ-033 All outputs except dbus SHALL be registered.

Reset
REQ-034 While rst=1, regardless of state or clock: state=IDLE; wr_en=0; rd_en=0; dbus high-Z; abus=IDLE_ADDR; rsp_valid=0; rsp_write=0; rsp_rdata=8'h00; cmd_ready=0; busy=1.
REQ-035 On the first rising edge after rst falls, cmd_ready SHALL become 1 and busy SHALL become 0.
REQ-036 Reset mid-transaction SHALL abort that transaction with no rsp_valid and no further strobe.

Verification
REQ-037 Reset during WSTROBE (rst high for 20 ns) -> wr_en falls within the same cycle, dbus=Z, abus=8'h00, no rsp_valid; cmd_ready=1 one edge after release.
REQ-038 Write addr 8'h00 data 8'hA5 to port_io (base_addr 8'h00) -> wr_en high exactly 1 cycle with abus=8'h00 and dbus=8'hA5; rsp_valid on cycle 3 with rsp_write=1.
REQ-039 Read addr 8'h00, WAIT_CYCLES=2, responder drives 8'h3C -> rd_en high exactly 3 cycles; rsp_valid on cycle 5 with rsp_rdata=8'h3C; dbus not driven by the master at any point.
REQ-040 cmd_valid held high with a write then a read queued -> second command accepted only when cmd_ready returns; strobes do not overlap; one rsp_valid per command.
REQ-041 cmd_valid pulsed while busy=1 -> no accept, no extra strobe, and the current transaction completes unchanged.
REQ-042 Random 1000-command run with an assertion monitor -> wr_en&rd_en never 1; dbus never driven during rd_en; number of rsp_valid pulses equals number of accepted commands.
